lsu_mem_responder: RTL and testbench
====================================

// Module: lsu_mem_responder
// PURPOSE
//  Memory-side responder for lsu_control. Accepts at most one load issue (load_executed + LDQ index)
//  and one store commit (store_executed + STQ index) per cycle, performs the access on an internal
//  word-addressed data RAM, and returns tagged responses after a fixed LATENCY through a valid-tagged
//  pipeline. The load response writes back into the LDQ; the store ack frees the STQ head.
// PARAMETERS
//  MEM_WORDS  1024  data RAM depth in 32-bit words; power of two
//  LATENCY    2     issue-to-response cycles; >= 1
//  (LDQ_SIZE, STQ_SIZE come from lsu_pkg)
// PORTS
//  clk                   in   1                  clock
//  reset_n               in   1                  asynchronous, active-low reset
//  flush                 in   1                  kill all in-flight load responses
//  load_executed         in   1                  load issue this cycle
//  ldq_mem_stage_index   in   $clog2(LDQ_SIZE)   LDQ tag of the issued load
//  load_address          in   32                 byte address of the load
//  load_funct3           in   3                  LB=000 LH=001 LW=010 LBU=100 LHU=101
//  store_executed        in   1                  store commit this cycle
//  store_executed_index  in   $clog2(STQ_SIZE)   STQ tag of the committed store
//  store_address         in   32                 byte address of the store
//  store_data            in   32                 store data, right-aligned
//  store_funct3          in   3                  SB=000 SH=001 SW=010
//  load_resp_valid       out  1                  load response valid
//  load_resp_index       out  $clog2(LDQ_SIZE)   LDQ tag of the response
//  load_resp_data        out  32                 extended load data; 0 when misaligned
//  load_resp_misaligned  out  1                  load was misaligned; no data returned
//  store_ack_valid       out  1                  store completed
//  store_ack_index       out  $clog2(STQ_SIZE)   STQ tag of the completed store
//  store_ack_misaligned  out  1                  store was misaligned; RAM not written
// BEHAVIOUR
//  - Reset (async, reset_n=0): clear all pipeline valid bits; every output = 0. RAM contents are
//    not reset. Reset mid-operation discards every in-flight response.
//  - Issue cycle T: the load reads the RAM combinationally and extracts/extends at issue. The
//    result enters stage 0. The store write is performed at the clk edge ending cycle T.
//  - Outputs are registered from stage LATENCY-1. A request issued in cycle T produces its
//    response valid in cycle T+LATENCY, for exactly one cycle.
//  - Full throughput: one load and one store per cycle. No backpressure, no ready signal.
//  - Load and store in the same cycle are both legal:
//    - The load returns pre-store RAM data. Forwarding is the LSU searcher's job.
//    - Both responses are emitted in the same cycle T+LATENCY.
//  - Word index = addr[$clog2(MEM_WORDS)+1:2]. Upper address bits are ignored (wrap).
//  - Alignment: a half access needs addr[0]=0; a word access needs addr[1:0]=00.
//    - Misaligned load: data=0, misaligned=1.
//    - Misaligned store: no RAM write, ack misaligned=1.
//    - Reserved funct3 is treated as misaligned.
//  - Load extract: the byte/half is selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
//  - Store merge: read-modify-write of the byte lanes selected by addr[1:0] and the size.
//    Other lanes are preserved.
//  - flush: clears the load valid in every stage, and any load issued in the same cycle is dropped.
//    Store stages are unaffected, because committed stores always complete and ack.
//  - Tags pass through unmodified; there is no ordering check on indices.
// STRUCTURE
//  - lsu_pkg gains:
//    - localparams MEM_LB/LH/LW/LBU/LHU and MEM_SB/SH/SW
//    - typedef mem_pipe_entry {ld_valid, ld_index, ld_data, ld_misaligned,
//      st_valid, st_index, st_misaligned}
//  - Sub-module lsu_mem_align (combinational): load extract/extend, store lane merge, misalignment
//    detect. The responder instantiates it once for the load path and once for the store path.
//  - Pipeline: array of LATENCY mem_pipe_entry registers.
// TESTING
//  - SW 0xDEADBEEF @0x10 (T0), LW @0x10 (T1) -> ack @T2, load_resp_data=0xDEADBEEF @T3 (LATENCY=2)
//  - RAM word@0x20=0x00008080; LB@0x20 -> 0xFFFFFF80; LBU@0x20 -> 0x00000080; LH@0x20 -> 0xFFFF8080
//  - LW @0x22 idx3 -> load_resp_misaligned=1, data=0; SH @0x21 -> ack misaligned=1, RAM unchanged
//  - Load idx1 @T0, flush @T1 -> no load_resp_valid ever; store issued @T0 still acks @T2
//  - Loads idx0..3 on consecutive cycles -> responses on 4 consecutive cycles, indices 0,1,2,3 in order
//  - Same-cycle SB 0xAA @0x4 and LBU @0x4 (old 0x11) -> load data 0x11; later LBU -> 0xAA;
//    address 0x4+4*MEM_WORDS aliases 0x4

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: queue sizes, memory access encodings and the
// responder pipeline entry.
package lsu_pkg;

  localparam int unsigned LDQ_SIZE  = 8;
  localparam int unsigned STQ_SIZE  = 8;
  localparam int unsigned LDQ_IDX_W = $clog2(LDQ_SIZE);
  localparam int unsigned STQ_IDX_W = $clog2(STQ_SIZE);

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;
  localparam logic [2:0] MEM_SB  = 3'b000;
  localparam logic [2:0] MEM_SH  = 3'b001;
  localparam logic [2:0] MEM_SW  = 3'b010;

  typedef struct packed {
    logic                 ld_valid;
    logic [LDQ_IDX_W-1:0] ld_index;
    logic [31:0]          ld_data;
    logic                 ld_misaligned;
    logic                 st_valid;
    logic [STQ_IDX_W-1:0] st_index;
    logic                 st_misaligned;
  } mem_pipe_entry;

  // Reserved encodings (including unsigned sizes on stores) count as misaligned.
  function automatic logic access_misaligned(input logic       is_store,
                                             input logic [2:0] funct3,
                                             input logic [1:0] byte_off);
    logic mis;
    case (funct3)
      MEM_LB:  mis = 1'b0;
      MEM_LH:  mis = byte_off[0];
      MEM_LW:  mis = (byte_off != 2'b00);
      MEM_LBU: mis = is_store;
      MEM_LHU: mis = is_store | byte_off[0];
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_align.sv
// Combinational lane logic for one memory access: load extract/extend,
// store byte-lane merge and misalignment detection.
module lsu_mem_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word,
  output logic        misaligned
);

  logic [31:0] shifted;
  logic [3:0]  lane_en;
  logic [31:0] wrep;

  always_comb begin
    misaligned = access_misaligned(is_store, funct3, byte_off);
    shifted    = rdata >> {byte_off, 3'b000};
    ld_data    = '0;
    if (!is_store && !misaligned) begin
      case (funct3)
        MEM_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
        MEM_LH:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
        MEM_LW:  ld_data = rdata;
        MEM_LBU: ld_data = {24'h0, shifted[7:0]};
        MEM_LHU: ld_data = {16'h0, shifted[15:0]};
        default: ld_data = '0;
      endcase
    end
  end

  // Replicate the store data across lanes so any enabled lane picks up the right bits.
  always_comb begin
    lane_en = '0;
    wrep    = '0;
    case (funct3)
      MEM_SB: begin
        lane_en = 4'b0001 << byte_off;
        wrep    = {4{wdata[7:0]}};
      end
      MEM_SH: begin
        lane_en = 4'b0011 << byte_off;
        wrep    = {2{wdata[15:0]}};
      end
      MEM_SW: begin
        lane_en = 4'b1111;
        wrep    = wdata;
      end
      default: begin
        lane_en = '0;
        wrep    = '0;
      end
    endcase
    if (!is_store || misaligned) lane_en = '0;
    st_word = rdata;
    for (int unsigned i = 0; i < 4; i++) begin
      if (lane_en[i]) st_word[8*i +: 8] = wrep[8*i +: 8];
    end
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// Memory-side responder for lsu_control: word RAM plus a fixed-latency
// tagged response pipeline for one load and one store per cycle.
module lsu_mem_responder
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 load_executed,
  input  logic [LDQ_IDX_W-1:0] ldq_mem_stage_index,
  input  logic [31:0]          load_address,
  input  logic [2:0]           load_funct3,
  input  logic                 store_executed,
  input  logic [STQ_IDX_W-1:0] store_executed_index,
  input  logic [31:0]          store_address,
  input  logic [31:0]          store_data,
  input  logic [2:0]           store_funct3,
  output logic                 load_resp_valid,
  output logic [LDQ_IDX_W-1:0] load_resp_index,
  output logic [31:0]          load_resp_data,
  output logic                 load_resp_misaligned,
  output logic                 store_ack_valid,
  output logic [STQ_IDX_W-1:0] store_ack_index,
  output logic                 store_ack_misaligned
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [31:0]   mem_q [MEM_WORDS];
  logic [AW-1:0] ld_widx;
  logic [AW-1:0] st_widx;
  logic [31:0]   ld_rdata;
  logic [31:0]   st_rdata;
  logic [31:0]   ld_data;
  logic          ld_mis;
  logic [31:0]   st_word;
  logic          st_mis;
  logic          st_we;
  logic [31:0]   unused_ld_merge;
  logic [31:0]   unused_st_ldata;
  logic          unused_addr_bits;

  mem_pipe_entry issue_e;
  mem_pipe_entry pipe_d [LATENCY];
  mem_pipe_entry pipe_q [LATENCY];

  assign ld_widx          = load_address[AW+1:2];
  assign st_widx          = store_address[AW+1:2];
  assign unused_addr_bits = ^{load_address[31:AW+2], store_address[31:AW+2]};
  assign ld_rdata         = mem_q[ld_widx];
  assign st_rdata         = mem_q[st_widx];

  lsu_mem_align u_ld_align (
    .is_store   (1'b0),
    .byte_off   (load_address[1:0]),
    .funct3     (load_funct3),
    .rdata      (ld_rdata),
    .wdata      ('0),
    .ld_data    (ld_data),
    .st_word    (unused_ld_merge),
    .misaligned (ld_mis)
  );

  lsu_mem_align u_st_align (
    .is_store   (1'b1),
    .byte_off   (store_address[1:0]),
    .funct3     (store_funct3),
    .rdata      (st_rdata),
    .wdata      (store_data),
    .ld_data    (unused_st_ldata),
    .st_word    (st_word),
    .misaligned (st_mis)
  );

  assign st_we = store_executed && !st_mis;

  // The load path reads before this edge, so a same-cycle load sees pre-store data.
  always_ff @(posedge clk) begin
    if (st_we) mem_q[st_widx] <= st_word;
  end

  always_comb begin
    issue_e = '0;
    if (load_executed && !flush) begin
      issue_e.ld_valid      = 1'b1;
      issue_e.ld_index      = ldq_mem_stage_index;
      issue_e.ld_data       = ld_data;
      issue_e.ld_misaligned = ld_mis;
    end
    if (store_executed) begin
      issue_e.st_valid      = 1'b1;
      issue_e.st_index      = store_executed_index;
      issue_e.st_misaligned = st_mis;
    end
  end

  // Flush zeroes the whole load half of each entry so idle outputs stay at 0.
  always_comb begin
    pipe_d    = '{default: '0};
    pipe_d[0] = issue_e;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    if (flush) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_d[i].ld_valid      = 1'b0;
        pipe_d[i].ld_index      = '0;
        pipe_d[i].ld_data       = '0;
        pipe_d[i].ld_misaligned = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign load_resp_valid      = pipe_q[LATENCY-1].ld_valid;
  assign load_resp_index      = pipe_q[LATENCY-1].ld_index;
  assign load_resp_data       = pipe_q[LATENCY-1].ld_data;
  assign load_resp_misaligned = pipe_q[LATENCY-1].ld_misaligned;
  assign store_ack_valid      = pipe_q[LATENCY-1].st_valid;
  assign store_ack_index      = pipe_q[LATENCY-1].st_index;
  assign store_ack_misaligned = pipe_q[LATENCY-1].st_misaligned;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Bench for lsu_mem_responder: byte-array memory model with a per-cycle
// response schedule, checked every cycle, plus literal pins on the model.
module tb_lsu_mem_responder;
  import lsu_pkg::*;

  localparam int unsigned MW  = 1024;
  localparam int unsigned LAT = 2;
  localparam int unsigned NB  = 4 * MW;
  localparam int          NC  = 1024;

  logic                 clk;
  logic                 reset_n;
  logic                 flush;
  logic                 load_executed;
  logic [LDQ_IDX_W-1:0] ldq_mem_stage_index;
  logic [31:0]          load_address;
  logic [2:0]           load_funct3;
  logic                 store_executed;
  logic [STQ_IDX_W-1:0] store_executed_index;
  logic [31:0]          store_address;
  logic [31:0]          store_data;
  logic [2:0]           store_funct3;
  logic                 load_resp_valid;
  logic [LDQ_IDX_W-1:0] load_resp_index;
  logic [31:0]          load_resp_data;
  logic                 load_resp_misaligned;
  logic                 store_ack_valid;
  logic [STQ_IDX_W-1:0] store_ack_index;
  logic                 store_ack_misaligned;

  lsu_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .flush                (flush),
    .load_executed        (load_executed),
    .ldq_mem_stage_index  (ldq_mem_stage_index),
    .load_address         (load_address),
    .load_funct3          (load_funct3),
    .store_executed       (store_executed),
    .store_executed_index (store_executed_index),
    .store_address        (store_address),
    .store_data           (store_data),
    .store_funct3         (store_funct3),
    .load_resp_valid      (load_resp_valid),
    .load_resp_index      (load_resp_index),
    .load_resp_data       (load_resp_data),
    .load_resp_misaligned (load_resp_misaligned),
    .store_ack_valid      (store_ack_valid),
    .store_ack_index      (store_ack_index),
    .store_ack_misaligned (store_ack_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          lv;
    int unsigned li;
    logic [31:0] ld;
    bit          lm;
    bit          sv;
    int unsigned si;
    bit          sm;
  } exp_t;

  exp_t       ex [NC];
  logic [7:0] mb [NB];
  int         cyc;
  int         n_cmp;
  int         n_fail;
  bit         done;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned size_of(input logic [2:0] f3, input bit is_store);
    case (f3)
      3'b000:  return 1;
      3'b001:  return 2;
      3'b010:  return 4;
      3'b100:  return is_store ? 0 : 1;
      3'b101:  return is_store ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_load(input logic [31:0] addr, input logic [2:0] f3,
                            output bit mis, output logic [31:0] data);
    int unsigned ba;
    int unsigned sz;
    longint      v;
    ba   = addr % NB;
    sz   = size_of(f3, 1'b0);
    mis  = (sz == 0) || ((ba % sz) != 0);
    data = '0;
    if (!mis) begin
      v = 0;
      for (int k = 0; k < int'(sz); k++) v = v | (longint'(mb[ba + k]) << (8 * k));
      if ((f3 == 3'b000 || f3 == 3'b001) && v[8 * sz - 1]) v = v | (-(longint'(1) << (8 * sz)));
      data = v[31:0];
    end
  endtask

  task automatic model_store(input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] data, output bit mis);
    int unsigned ba;
    int unsigned sz;
    logic [31:0] d;
    ba  = addr % NB;
    sz  = size_of(f3, 1'b1);
    mis = (sz == 0) || ((ba % sz) != 0);
    d   = data;
    if (!mis) for (int k = 0; k < int'(sz); k++) mb[ba + k] = d[8*k +: 8];
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic issue(input bit ld, input int unsigned lidx, input logic [31:0] la,
                       input logic [2:0] lf, input bit st, input int unsigned sidx,
                       input logic [31:0] sa, input logic [31:0] sd, input logic [2:0] sf,
                       input bit fl);
    int          t;
    bit          m;
    logic [31:0] d;
    load_executed        = ld;
    ldq_mem_stage_index  = LDQ_IDX_W'(lidx);
    load_address         = la;
    load_funct3          = lf;
    store_executed       = st;
    store_executed_index = STQ_IDX_W'(sidx);
    store_address        = sa;
    store_data           = sd;
    store_funct3         = sf;
    flush                = fl;
    t = cyc;
    if (fl) begin
      for (int k = 1; k <= int'(LAT); k++) begin
        ex[t + k].lv = 0; ex[t + k].li = 0; ex[t + k].ld = '0; ex[t + k].lm = 0;
      end
    end
    if (ld && !fl) begin
      model_load(la, lf, m, d);
      ex[t + LAT].lv = 1; ex[t + LAT].li = lidx % LDQ_SIZE;
      ex[t + LAT].ld = d; ex[t + LAT].lm = m;
    end
    if (st) begin
      model_store(sa, sf, sd, m);
      ex[t + LAT].sv = 1; ex[t + LAT].si = sidx % STQ_SIZE; ex[t + LAT].sm = m;
    end
    @(posedge clk);
    #1;
    load_executed  = 1'b0;
    store_executed = 1'b0;
    flush          = 1'b0;
    load_address   = '0;
    store_address  = '0;
    store_data     = '0;
  endtask

  task automatic ld_op(input int unsigned idx, input logic [31:0] a, input logic [2:0] f);
    issue(1, idx, a, f, 0, 0, '0, '0, 3'b000, 0);
  endtask

  task automatic st_op(input int unsigned idx, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f);
    issue(0, 0, '0, 3'b000, 1, idx, a, d, f, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) issue(0, 0, '0, 3'b000, 0, 0, '0, '0, 3'b000, 0);
  endtask

  // Scheduled result of the request issued in the previous cycle.
  function automatic exp_t last();
    return ex[cyc - 1 + LAT];
  endfunction

  initial begin : compare
    logic [LDQ_IDX_W+33:0] got_l, want_l;
    logic [STQ_IDX_W+1:0]  got_s, want_s;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done) begin
        e      = ex[cyc];
        got_l  = {load_resp_valid, load_resp_index, load_resp_data, load_resp_misaligned};
        want_l = {e.lv, LDQ_IDX_W'(e.li), e.ld, e.lm};
        got_s  = {store_ack_valid, store_ack_index, store_ack_misaligned};
        want_s = {e.sv, STQ_IDX_W'(e.si), e.sm};
        n_cmp += 2;
        if (got_l !== want_l) begin
          n_fail++;
          $display("FAIL load_resp cyc=%0d {v,idx,data,mis}: got %h want %h", cyc, got_l, want_l);
        end
        if (got_s !== want_s) begin
          n_fail++;
          $display("FAIL store_ack cyc=%0d {v,idx,mis}: got %h want %h", cyc, got_s, want_s);
        end
      end
    end
  end

  initial begin : drive
    exp_t        e;
    int unsigned r;
    logic [2:0]  lf_tab [5];
    lf_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    cyc = 0; n_cmp = 0; n_fail = 0; done = 0;
    for (int i = 0; i < NC; i++) ex[i] = '{0, 0, '0, 0, 0, 0, 0};
    for (int i = 0; i < int'(NB); i++) mb[i] = '0;
    flush = 0; load_executed = 0; store_executed = 0;
    ldq_mem_stage_index = '0; store_executed_index = '0;
    load_address = '0; store_address = '0; store_data = '0;
    load_funct3 = '0; store_funct3 = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    pin("reset_load_valid", {31'h0, load_resp_valid}, 32'h0);

    // SW then LW of the same word.
    st_op(2, 32'h10, 32'hDEADBEEF, MEM_SW);
    ld_op(5, 32'h10, MEM_LW);
    @(negedge clk);
    pin("sw_ack_valid", {31'h0, store_ack_valid}, 32'h1);
    idle(1);
    @(negedge clk);
    pin("lw_data", load_resp_data, 32'hDEADBEEF);
    pin("lw_index", 32'(load_resp_index), 32'd5);

    // Sign/zero extension.
    st_op(0, 32'h20, 32'h00008080, MEM_SW);
    ld_op(0, 32'h20, MEM_LB);  e = last(); pin("lb_model", e.ld, 32'hFFFFFF80);
    ld_op(1, 32'h20, MEM_LBU); e = last(); pin("lbu_model", e.ld, 32'h00000080);
    ld_op(2, 32'h20, MEM_LH);  e = last(); pin("lh_model", e.ld, 32'hFFFF8080);

    // Misalignment.
    ld_op(3, 32'h22, MEM_LW);  e = last(); pin("lw_mis_model", {e.ld[30:0], e.lm}, 32'h1);
    st_op(6, 32'h21, 32'h1234, MEM_SH); e = last(); pin("sh_mis_model", {31'h0, e.sm}, 32'h1);
    ld_op(4, 32'h20, MEM_LW);  e = last(); pin("ram_unchanged_model", e.ld, 32'h00008080);
    ld_op(7, 32'h0, 3'b011);   e = last(); pin("ld_rsvd_model", {31'h0, e.lm}, 32'h1);
    st_op(1, 32'h8, 32'h5, 3'b100); e = last(); pin("st_rsvd_model", {31'h0, e.sm}, 32'h1);

    // Flush kills in-flight and same-cycle loads; the store still acks.
    issue(1, 1, 32'h10, MEM_LW, 1, 4, 32'h40, 32'hCAFEF00D, MEM_SW, 0);
    issue(1, 2, 32'h10, MEM_LW, 0, 0, '0, '0, 3'b000, 1);
    e = ex[cyc - 2 + LAT]; pin("flush_kill_model", {30'h0, e.lv, e.sv}, 32'h1);
    e = last();            pin("flush_drop_model", {31'h0, e.lv}, 32'h0);
    @(negedge clk);
    pin("flush_store_ack", {31'h0, store_ack_valid}, 32'h1);
    pin("flush_no_load", {31'h0, load_resp_valid}, 32'h0);
    idle(2);

    // Back-to-back loads.
    for (int i = 0; i < 4; i++) ld_op(i, (i % 2 == 0) ? 32'h10 : 32'h20, MEM_LW);
    @(negedge clk);
    pin("b2b_first_index", {31'h0, load_resp_valid, 1'b0} | 32'(load_resp_index), 32'h2);
    idle(3);

    // Same-cycle store and load; address wrap.
    st_op(0, 32'h4, 32'h44332211, MEM_SW);
    issue(1, 3, 32'h4, MEM_LBU, 1, 3, 32'h4, 32'hAA, MEM_SB, 0);
    e = last(); pin("same_cycle_model", e.ld, 32'h11);
    ld_op(4, 32'h4 + 4 * MW, MEM_LBU);  e = last(); pin("alias_model", e.ld, 32'hAA);
    ld_op(5, 32'h80000004, MEM_LW);     e = last(); pin("merge_w_model", e.ld, 32'h443322AA);

    // Byte/half lane merges.
    st_op(2, 32'h11, 32'h55, MEM_SB);
    ld_op(0, 32'h12, MEM_LHU); e = last(); pin("lhu_model", e.ld, 32'h0000DEAD);
    ld_op(1, 32'h12, MEM_LH);  e = last(); pin("lh_neg_model", e.ld, 32'hFFFFDEAD);
    ld_op(2, 32'h13, MEM_LB);  e = last(); pin("lb_hi_model", e.ld, 32'hFFFFFFDE);
    st_op(3, 32'h12, 32'h1234, MEM_SH);
    ld_op(3, 32'h10, MEM_LW);  e = last(); pin("sh_merge_model", e.ld, 32'h123455EF);
    idle(2);

    // Reset while responses are in flight.
    ld_op(1, 32'h10, MEM_LW);
    st_op(1, 32'h10, 32'h0BADF00D, MEM_SW);
    reset_n = 1'b0;
    for (int i = cyc; i < cyc + int'(LAT) + 2; i++) ex[i] = '{0, 0, '0, 0, 0, 0, 0};
    idle(2);
    reset_n = 1'b1;
    ld_op(6, 32'h10, MEM_LW);  e = last(); pin("ram_kept_model", e.ld, 32'h0BADF00D);
    idle(2);

    // Mixed traffic over an initialised region.
    for (int i = 0; i < 16; i++) st_op(i % STQ_SIZE, 32'h100 + 4 * i, $urandom, MEM_SW);
    for (int i = 0; i < 48; i++) begin
      r = $urandom;
      issue(r[0], $urandom_range(0, LDQ_SIZE - 1), 32'h100 + $urandom_range(0, 63),
            lf_tab[$urandom_range(0, 4)], r[1], $urandom_range(0, STQ_SIZE - 1),
            32'h100 + $urandom_range(0, 63), $urandom, 3'($urandom_range(0, 2)),
            (r[4:2] == 3'b000));
    end
    idle(LAT + 2);

    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
